// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit RISC core: opcodes, control-unit states,
// PC-source / ALU-op selects and the static decode bundle.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_ANDI = 4'd3,
    OP_ADDI = 4'd4,  OP_LW   = 4'd5,  OP_LBU  = 4'd6,  OP_LBS  = 4'd7,
    OP_SW   = 4'd8,  OP_BGT  = 4'd9,  OP_BLT  = 4'd10, OP_BEQ  = 4'd11,
    OP_JMP  = 4'd12, OP_CALL = 4'd13, OP_RET  = 4'd14, OP_SV   = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RETURN = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10
  } aluop_t;

  // Instruction class picks the stage route after ID.
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4
  } opclass_t;

  typedef struct packed {
    opclass_t cls;
    aluop_t   alu_op;
    logic     alu_src;
    logic     ext;
    logic     rb;
    logic     wb;
    logic     add_addr;
    logic     add_data;
    logic     sv_mode;
  } ctrl_t;

endpackage

// File: rtl/cu_decoder.sv
// Pure-combinational opcode decode into the state-independent control bundle.
module cu_decoder
  import cpu_pkg::*;
(
  input  opcode_t opcode_i,
  input  logic    mode_i,
  output ctrl_t   ctrl_o
);

  always_comb begin
    ctrl_o     = '0;
    ctrl_o.cls = CLS_ALU;
    unique case (opcode_i)
      OP_AND:  ctrl_o.alu_op = ALU_AND;
      OP_ADD:  ctrl_o.alu_op = ALU_ADD;
      OP_SUB:  ctrl_o.alu_op = ALU_SUB;
      OP_ANDI: begin
        ctrl_o.alu_op  = ALU_AND;
        ctrl_o.alu_src = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.alu_op  = ALU_ADD;
        ctrl_o.alu_src = 1'b1;
        ctrl_o.ext     = 1'b1;
      end
      OP_LW, OP_LBU, OP_LBS: begin
        ctrl_o.cls     = CLS_LOAD;
        ctrl_o.alu_op  = ALU_ADD;
        ctrl_o.alu_src = 1'b1;
        ctrl_o.ext     = (opcode_i != OP_LBU);
        ctrl_o.wb      = 1'b1;
      end
      OP_SW: begin
        ctrl_o.cls     = CLS_STORE;
        ctrl_o.alu_op  = ALU_ADD;
        ctrl_o.alu_src = 1'b1;
        ctrl_o.ext     = 1'b1;
        ctrl_o.rb      = 1'b1;
      end
      OP_BGT, OP_BLT, OP_BEQ: begin
        ctrl_o.cls    = CLS_BRANCH;
        ctrl_o.alu_op = ALU_SUB;
        ctrl_o.ext    = 1'b1;
        ctrl_o.rb     = 1'b1;
      end
      OP_JMP, OP_CALL, OP_RET: ctrl_o.cls = CLS_JUMP;
      OP_SV: begin
        ctrl_o.cls      = CLS_STORE;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.ext      = mode_i;
        ctrl_o.add_addr = 1'b1;
        ctrl_o.add_data = 1'b1;
        ctrl_o.sv_mode  = mode_i;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle IF/ID/EX/MEM/WB control unit. Define CU_STATE_OUT_EN to expose
// the raw state encoding on dbgState.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] instructionCode,
  input  logic       zeroFlag,
  input  logic       mode,
  output logic       enIF,
  output logic       enID,
  output logic       enE,
  output logic       enMem,
  output logic       enWRB,
  output logic [1:0] sigPCSrc,
  output logic [1:0] sigALUOp,
  output logic       sigRB,
  output logic       sigALUSrc,
  output logic       sigExt,
  output logic       sigDstReg,
  output logic       sigWB,
  output logic       sigENW1,
  output logic       sigENW2,
  output logic       sigMemR,
  output logic       sigMemW,
  output logic       sigAddAddress,
  output logic       sigAddData,
  output logic       sigMode
`ifdef CU_STATE_OUT_EN
  ,
  output logic [2:0] dbgState
`endif
);

  state_t  state_q, state_d;
  opcode_t op_q;
  logic    mode_q;
  ctrl_t   ctrl;
  logic    active;

  cu_decoder u_dec (
    .opcode_i (op_q),
    .mode_i   (mode_q),
    .ctrl_o   (ctrl)
  );

  always_comb begin
    state_d = ST_IF;
    unique case (state_q)
      ST_IF:  state_d = ST_ID;
      ST_ID:  state_d = (ctrl.cls == CLS_JUMP) ? ST_IF : ST_EX;
      ST_EX: begin
        unique case (ctrl.cls)
          CLS_ALU:             state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_IF;
        endcase
      end
      ST_MEM: state_d = (ctrl.cls == CLS_LOAD) ? ST_WB : ST_IF;
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IF;
      op_q    <= OP_AND;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IF) begin
        op_q   <= opcode_t'(instructionCode);
        mode_q <= mode;
      end
    end
  end

  // Static decode is held off in IF, where op_q still names the previous instruction.
  assign active = (state_q != ST_IF);

  always_comb begin
    enIF          = (state_q == ST_IF);
    enID          = (state_q == ST_ID);
    enE           = (state_q == ST_EX);
    enMem         = (state_q == ST_MEM);
    enWRB         = (state_q == ST_WB);
    sigALUOp      = active ? ctrl.alu_op : ALU_AND;
    sigALUSrc     = active & ctrl.alu_src;
    sigExt        = active & ctrl.ext;
    sigRB         = active & ctrl.rb;
    sigWB         = active & ctrl.wb;
    sigAddAddress = active & ctrl.add_addr;
    sigAddData    = active & ctrl.add_data;
    sigMode       = active & ctrl.sv_mode;
    sigENW1       = (state_q == ST_WB) && (ctrl.cls == CLS_ALU || ctrl.cls == CLS_LOAD);
    sigMemR       = (state_q == ST_MEM) && (ctrl.cls == CLS_LOAD);
    sigMemW       = (state_q == ST_MEM) && (ctrl.cls == CLS_STORE);
    sigENW2       = (state_q == ST_ID) && (op_q == OP_CALL);
    sigDstReg     = (state_q == ST_ID) && (op_q == OP_CALL);
    sigPCSrc      = PC_INC;
    if (state_q == ST_EX && ctrl.cls == CLS_BRANCH && zeroFlag)
      sigPCSrc = PC_BRANCH;
    else if (state_q == ST_ID && (op_q == OP_JMP || op_q == OP_CALL))
      sigPCSrc = PC_JUMP;
    else if (state_q == ST_ID && op_q == OP_RET)
      sigPCSrc = PC_RETURN;
  end

`ifdef CU_STATE_OUT_EN
  assign dbgState = state_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a stage-route model.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] instructionCode;
  logic       zeroFlag;
  logic       mode;
  logic       enIF, enID, enE, enMem, enWRB;
  logic [1:0] sigPCSrc, sigALUOp;
  logic       sigRB, sigALUSrc, sigExt, sigDstReg, sigWB, sigENW1, sigENW2;
  logic       sigMemR, sigMemW, sigAddAddress, sigAddData, sigMode;
`ifdef CU_STATE_OUT_EN
  logic [2:0] dbgState;
`endif

  control_unit dut (
    .clock(clock), .reset(reset), .instructionCode(instructionCode),
    .zeroFlag(zeroFlag), .mode(mode),
    .enIF(enIF), .enID(enID), .enE(enE), .enMem(enMem), .enWRB(enWRB),
    .sigPCSrc(sigPCSrc), .sigALUOp(sigALUOp), .sigRB(sigRB),
    .sigALUSrc(sigALUSrc), .sigExt(sigExt), .sigDstReg(sigDstReg),
    .sigWB(sigWB), .sigENW1(sigENW1), .sigENW2(sigENW2),
    .sigMemR(sigMemR), .sigMemW(sigMemW), .sigAddAddress(sigAddAddress),
    .sigAddData(sigAddData), .sigMode(sigMode)
`ifdef CU_STATE_OUT_EN
    , .dbgState(dbgState)
`endif
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  // Model: current stage (0 IF,1 ID,2 EX,3 MEM,4 WB), position in route, latched op/mode.
  int         cur   = 0;
  int         pos   = 0;
  logic [3:0] m_op  = '0;
  logic       m_md  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (stage=%0d op=%0d)", tag, got, exp, cur, m_op);
    end
  endtask

  // Stages visited after IF, listed per instruction class.
  function automatic int stage_at(input logic [3:0] op, input int i);
    int path[4];
    int n;
    if (op <= 4)                   begin path = '{1, 2, 4, 0}; n = 3; end
    else if (op <= 7)              begin path = '{1, 2, 3, 4}; n = 4; end
    else if (op == 8 || op == 15)  begin path = '{1, 2, 3, 0}; n = 3; end
    else if (op <= 11)             begin path = '{1, 2, 0, 0}; n = 2; end
    else                           begin path = '{1, 0, 0, 0}; n = 1; end
    return (i < n) ? path[i] : 0;
  endfunction

  // Expected {pcsrc[1:0], aluop[1:0], rb, alusrc, ext, dst, wb, enw1, enw2, memr, memw, addaddr, adddata, mode}.
  function automatic logic [15:0] exp_ctl(input int st, input logic [3:0] op, input logic md, input logic zf);
    bit ld  = (op >= 5 && op <= 7);
    bit br  = (op >= 9 && op <= 11);
    bit sw  = (op == 8);
    bit sv  = (op == 15);
    bit act = (st != 0);
    logic [1:0] pc = 2'd0;
    logic [1:0] alu = 2'd0;
    if (st == 2 && br && zf)                 pc = 2'd1;
    if (st == 1 && (op == 12 || op == 13))   pc = 2'd2;
    if (st == 1 && op == 14)                 pc = 2'd3;
    if (act) begin
      if (op == 2 || br)                                  alu = 2'd2;
      else if (op == 1 || op == 4 || ld || sw || sv)      alu = 2'd1;
    end
    return {pc, alu,
            1'(act && (sw || br)),
            1'(act && (op == 3 || op == 4 || ld || sw)),
            1'(act && (op == 4 || op == 5 || op == 7 || sw || br || (sv && md))),
            1'(st == 1 && op == 13),
            1'(act && ld),
            1'(st == 4 && op <= 7),
            1'(st == 1 && op == 13),
            1'(st == 3 && ld),
            1'(st == 3 && (sw || sv)),
            1'(act && sv),
            1'(act && sv),
            1'(act && sv && md)};
  endfunction

  task automatic check_outputs(input string tag);
    logic [15:0] e;
    e = exp_ctl(cur, m_op, m_md, zeroFlag);
    check({tag, ".en"},    32'({enIF, enID, enE, enMem, enWRB}), 32'(5'b10000 >> cur));
    check({tag, ".pcsrc"}, 32'(sigPCSrc), 32'(e[15:14]));
    check({tag, ".aluop"}, 32'(sigALUOp), 32'(e[13:12]));
    check({tag, ".ctl"},
          32'({sigRB, sigALUSrc, sigExt, sigDstReg, sigWB, sigENW1, sigENW2,
               sigMemR, sigMemW, sigAddAddress, sigAddData, sigMode}),
          32'(e[11:0]));
`ifdef CU_STATE_OUT_EN
    check({tag, ".dbg"}, 32'(dbgState), 32'(cur));
`endif
  endtask

  task automatic advance();
    if (!reset) begin
      cur = 0; pos = 0; m_op = '0; m_md = 1'b0;
    end else if (cur == 0) begin
      m_op = instructionCode; m_md = mode; pos = 0;
      cur  = stage_at(m_op, 0);
    end else begin
      pos++;
      cur = stage_at(m_op, pos);
    end
  endtask

  function automatic logic pick_zf(input int zmode);
    return (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
  endfunction

  task automatic cycle(input string tag, input logic [3:0] op, input logic md, input logic zf);
    @(negedge clock);
    instructionCode = op;
    mode            = md;
    zeroFlag        = zf;
    #1;
    check_outputs(tag);
    @(posedge clock);
    advance();
  endtask

  // zmode: 0/1 force zeroFlag, 2 randomize it every cycle.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic md, input int zmode);
    int guard = 0;
    cycle(tag, op, md, pick_zf(zmode));
    while (cur != 0 && guard < 8) begin
      cycle(tag, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), pick_zf(zmode));
      guard++;
    end
    if (guard >= 8) check({tag, ".timeout"}, 32'(cur), 32'd0);
  endtask

  task automatic mid_ex_reset();
    cycle("rst_add", 4'd1, 1'b0, 1'b0);
    cycle("rst_add", 4'($urandom_range(0, 15)), 1'b1, 1'b1);
    @(negedge clock);
    instructionCode = 4'($urandom_range(0, 15));
    zeroFlag        = 1'b1;
    #1;
    check_outputs("rst_add_ex");
    reset = 1'b0;
    #1;
    advance();
    check_outputs("rst_abort");
    @(posedge clock);
    @(negedge clock);
    #1;
    check_outputs("rst_hold");
    @(posedge clock);
    #1 reset = 1'b1;
    run_instr("rst_restart", 4'd1, 1'b0, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b0;
    instructionCode = 4'd15;
    mode            = 1'b1;
    zeroFlag        = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check_outputs("reset");
    @(posedge clock);
    #1 reset = 1'b1;

    run_instr("add",   4'd1,  1'b0, 2);
    run_instr("lbs",   4'd7,  1'b0, 2);
    run_instr("lbu",   4'd6,  1'b1, 2);
    run_instr("beq_z", 4'd11, 1'b0, 1);
    run_instr("beq_n", 4'd11, 1'b0, 0);
    run_instr("jmp",   4'd12, 1'b0, 2);
    run_instr("call",  4'd13, 1'b1, 2);
    run_instr("ret",   4'd14, 1'b0, 2);
    run_instr("sv0",   4'd15, 1'b0, 2);
    run_instr("sv1",   4'd15, 1'b1, 2);
    run_instr("sw",    4'd8,  1'b1, 2);
    mid_ex_reset();

    for (int i = 0; i < 300; i++)
      run_instr("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM control unit for the 16-bit, 16-opcode RISC core.
- Sequences each instruction through the IF, ID, EX, MEM and WB stages and drives one-hot stage enables.
- Decodes the 4-bit opcode into datapath mux selects, register-file and memory write/read enables, and PC-source select.
- Sits between the instruction register, ALU flags and the datapath.

Parameters:
- None; all encodings come from the shared package.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instructionCode  in  4  opcode from the instruction register
- zeroFlag  in  1  ALU branch-condition flag
- mode  in  1  Sv variant bit from the instruction
- enIF, enID, enE, enMem, enWRB  out  1 each  one-hot stage enables
- sigPCSrc  out  2  PC source: 00 PC+1, 01 branch target, 10 jump target, 11 return address
- sigALUOp  out  2  ALU op: 00 AND, 01 ADD, 10 SUB
- sigRB  out  1  register-B read address: 0 Rt, 1 Rd
- sigALUSrc  out  1  ALU operand B: 0 register, 1 immediate
- sigExt  out  1  immediate extension: 1 sign, 0 zero
- sigDstReg  out  1  destination register: 0 Rd, 1 R7 (link)
- sigWB  out  1  writeback source: 0 ALU, 1 memory
- sigENW1  out  1  register-file write, port 1 (Rd)
- sigENW2  out  1  register-file write, port 2 (link / return address)
- sigMemR, sigMemW  out  1 each  data-memory read / write
- sigAddAddress  out  1  memory address: 0 ALU result, 1 register A
- sigAddData  out  1  memory write data: 0 register B, 1 immediate
- sigMode  out  1  latched mode, non-zero only for Sv

Behaviour:
- Opcodes:
  - 0 AND, 1 ADD, 2 SUB, 3 ANDI, 4 ADDI
  - 5 LW, 6 LBu, 7 LBs, 8 SW
  - 9 BGT, 10 BLT, 11 BEQ
  - 12 JMP, 13 CALL, 14 RET, 15 Sv
- States IF, ID, EX, MEM, WB. Exactly one enable is high, matching the current state.
- Opcode and mode are sampled into internal registers on the clock edge leaving IF. Decode in ID through WB uses the latched values.
- Transitions after ID:
  - ALU ops 0-4: EX→WB→IF (4 cycles)
  - Loads 5-7: EX→MEM→WB→IF (5 cycles)
  - SW and Sv: EX→MEM→IF (4 cycles)
  - Branches 9-11: EX→IF (3 cycles)
  - JMP, CALL, RET: ID→IF (2 cycles)
- All outputs are combinational from state, latched opcode and (EX only) zeroFlag. Default 0 when not asserted below.
- sigALUOp:
  - AND/ANDI → 00
  - ADD/ADDI, loads, SW, Sv → 01
  - SUB and branches → 10
- sigALUSrc = 1 for ANDI, ADDI, loads, SW.
- sigExt = 1 for ADDI, LW, LBs, SW, branches, and Sv with mode=1. It is 0 for ANDI and LBu.
- sigRB = 1 for SW and branches.
- sigWB = 1 for loads. sigENW1 is high only in WB for opcodes 0-7.
- sigMemR is high only in MEM for loads.
- sigMemW is high only in MEM for SW and Sv.
- Sv: sigAddAddress=1, sigAddData=1, sigMode = latched mode.
- Branch: in EX, sigPCSrc=01 iff zeroFlag=1, else 00.
- JMP and CALL: in ID, sigPCSrc=10.
- CALL: in ID, sigENW2=1 and sigDstReg=1.
- RET: in ID, sigPCSrc=11.
- sigPCSrc is 00 in every other state.
- Reset (asynchronous, low): state=IF, enIF=1, all other outputs 0, latched opcode=0, latched mode=0. Asserting reset mid-instruction aborts it immediately and holds IF until release.
- zeroFlag is ignored outside EX. Changes to instructionCode outside IF have no effect.

Optional Feature:
- CU_STATE_OUT_EN defined: adds output dbgState[2:0] carrying the state encoding (IF=0, ID=1, EX=2, MEM=3, WB=4).
- Undefined: port absent. Behaviour is otherwise identical.

Decomposition:
- Shared package `cpu_pkg`: opcode constants, state encoding, PCSrc and ALUOp encodings.
- Natural sub-module: `cu_decoder`, pure-combinational opcode-to-static-control decode. The FSM and output gating stay in control_unit.

Test Plan:
- Reset low mid-EX of ADD → immediately enIF=1, all control outputs 0. After release, the sequence restarts in IF.
- ADD (0001) → enables IF,ID,E,WRB over 4 cycles. ALUOp=01, ALUSrc=0, ENW1=1 only in WB.
- LBs (0111) → 5-cycle IF,ID,E,Mem,WRB. MemR=1 in MEM, WB=1, Ext=1, ENW1=1 in WB. LBu (0110) → same sequence with Ext=0.
- BEQ (1011): zeroFlag=1 → PCSrc=01 in EX. zeroFlag=0 → PCSrc=00. Both return to IF after 3 cycles, ENW1=0, MemW=0.
- JMP (1100) → PCSrc=10 in ID, 2 cycles. CALL (1101) → PCSrc=10, ENW2=1, DstReg=1 in ID. RET (1110) → PCSrc=11.
- Sv (1111), mode=0 then mode=1 → MemW=1 in MEM, AddAddress=1, AddData=1, Mode=0 then 1, 4 cycles each.
